// File: rtl/mips_mio_bridge.sv
// Handshaked, stalling memory bus master between the MIPS core and the MIO bus.
// Handles byte/half/word accesses, load extension, misalignment and bus timeout.
module mips_mio_bridge #(
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req,
   input  logic              we,
   input  logic [1:0]        size,
   input  logic              sign_ext,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic              stall,
   output logic [31:0]       rdata,
   output logic              done,
   output logic              err,
   output logic [CNT_W-1:0]  stall_cnt,
   input  logic              MIO_ready,
   input  logic [31:0]       Data_in,
   output logic              CPU_MIO,
   output logic              mem_w,
   output logic [ADDR_W-1:0] Addr_out,
   output logic [31:0]       Data_out,
   output logic [3:0]        be
);

   typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE, S_ERR} state_t;

   state_t              state_q, state_d;
   logic                we_q, we_d;
   logic [1:0]          size_q, size_d;
   logic                sign_ext_q, sign_ext_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [31:0]         wdata_q, wdata_d;
   logic [31:0]         tmo_q, tmo_d;
   logic [31:0]         rdata_q, rdata_d;
   logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

   logic                misaligned;
   logic [31:0]         lane_shift;
   logic [15:0]         lane_half;
   logic [31:0]         load_ext;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         we_q        <= 1'b0;
         size_q      <= 2'b00;
         sign_ext_q  <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         tmo_q       <= '0;
         rdata_q     <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         we_q        <= we_d;
         size_q      <= size_d;
         sign_ext_q  <= sign_ext_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         tmo_q       <= tmo_d;
         rdata_q     <= rdata_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign misaligned = ((size == 2'b01) && addr[0]) ||
                       (size[1] && (addr[1:0] != 2'b00));

   // Lane extraction from the bus word for the latched access.
   always_comb begin
      lane_shift = Data_in >> {addr_q[1:0], 3'b000};
      lane_half  = addr_q[1] ? Data_in[31:16] : Data_in[15:0];
      case (size_q)
         2'b00:   load_ext = sign_ext_q ? {{24{lane_shift[7]}}, lane_shift[7:0]}
                                        : {24'h000000, lane_shift[7:0]};
         2'b01:   load_ext = sign_ext_q ? {{16{lane_half[15]}}, lane_half}
                                        : {16'h0000, lane_half};
         default: load_ext = Data_in;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      we_d       = we_q;
      size_d     = size_q;
      sign_ext_d = sign_ext_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      tmo_d      = tmo_q;
      rdata_d    = rdata_q;
      stall      = 1'b0;
      done       = 1'b0;
      err        = 1'b0;
      CPU_MIO    = 1'b0;
      mem_w      = 1'b0;
      Addr_out   = '0;
      Data_out   = '0;
      be         = 4'b0000;

      case (state_q)
         S_IDLE: begin
            // Gated by rst_n so a held req cannot keep stall high during reset.
            stall = req & rst_n;
            if (req) begin
               if (misaligned) begin
                  state_d = S_ERR;
               end else begin
                  we_d       = we;
                  size_d     = size;
                  sign_ext_d = sign_ext;
                  addr_d     = addr;
                  wdata_d    = wdata;
                  tmo_d      = '0;
                  state_d    = S_BUS;
               end
            end
         end
         S_BUS: begin
            stall    = 1'b1;
            CPU_MIO  = 1'b1;
            mem_w    = we_q;
            Addr_out = {addr_q[ADDR_W-1:2], 2'b00};
            case (size_q)
               2'b00: begin
                  be       = 4'b0001 << addr_q[1:0];
                  Data_out = {4{wdata_q[7:0]}};
               end
               2'b01: begin
                  be       = addr_q[1] ? 4'b1100 : 4'b0011;
                  Data_out = {2{wdata_q[15:0]}};
               end
               default: begin
                  be       = 4'b1111;
                  Data_out = wdata_q;
               end
            endcase
            if (!we_q) Data_out = '0;
            if (MIO_ready) begin
               rdata_d = we_q ? 32'h0 : load_ext;
               state_d = S_DONE;
            end else begin
               tmo_d = tmo_q + 32'd1;
               if ((TIMEOUT != 0) && (tmo_q == 32'(TIMEOUT - 1))) state_d = S_ERR;
            end
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            err     = 1'b1;
            state_d = S_IDLE;
         end
      endcase

      stall_cnt_d = stall_cnt_q;
      if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
   end

   assign rdata     = (state_q == S_DONE) ? rdata_q : 32'h0;
   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_mips_mio_bridge.sv
// Directed-vector bench for mips_mio_bridge with immediate-assertion checks.
module tb_mips_mio_bridge;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req, we, sign_ext, MIO_ready;
   logic [1:0]  size;
   logic [31:0] addr, wdata, Data_in;
   logic        stall, done, err, CPU_MIO, mem_w;
   logic [31:0] rdata, stall_cnt, Addr_out, Data_out;
   logic [3:0]  be;

   int vectors     = 0;
   int miscompares = 0;

   // per-access observations
   int          n_stall, n_bus;
   logic        saw_done, saw_err, finished;
   logic [31:0] r_rdata, r_cnt, r_addr, r_dout;
   logic [3:0]  r_be;
   logic        r_memw;

   always #5 clk = ~clk;

   mips_mio_bridge #(.ADDR_W(32), .TIMEOUT(4), .CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size),
      .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .stall(stall),
      .rdata(rdata), .done(done), .err(err), .stall_cnt(stall_cnt),
      .MIO_ready(MIO_ready), .Data_in(Data_in), .CPU_MIO(CPU_MIO),
      .mem_w(mem_w), .Addr_out(Addr_out), .Data_out(Data_out), .be(be)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Runs one access starting 1ns after a posedge; ready asserts on BUS cycle
   // number (waits+1), or never when waits < 0.
   task automatic access(input logic w, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int waits, input logic [31:0] din);
      n_stall = 0; n_bus = 0; saw_done = 0; saw_err = 0; finished = 0;
      r_rdata = '0; r_cnt = '0; r_addr = '0; r_dout = '0; r_be = '0; r_memw = 0;
      req = 1; we = w; size = sz; sign_ext = sx; addr = a; wdata = wd; Data_in = din;
      for (int c = 0; c < 40; c++) begin
         #1;
         if (stall) n_stall++;
         if (CPU_MIO) begin
            n_bus++;
            if (n_bus == 1) begin
               r_addr = Addr_out; r_dout = Data_out; r_be = be; r_memw = mem_w;
            end
            MIO_ready = (waits >= 0) && (n_bus == waits + 1);
         end else begin
            MIO_ready = 0;
         end
         if (done || err) begin
            saw_done = done; saw_err = err; r_rdata = rdata; r_cnt = stall_cnt;
            req = 0; MIO_ready = 0; finished = 1;
         end
         @(posedge clk); #1;
         if (finished) break;
      end
      check("access_bounded", 32'(finished), 32'd1);
   endtask

   initial begin
      rst_n = 0; req = 0; we = 0; size = 2'b10; sign_ext = 0;
      addr = '0; wdata = '0; MIO_ready = 0; Data_in = '0;
      #12;
      check("rst_stall", 32'(stall), 0);
      check("rst_cpu_mio", 32'(CPU_MIO), 0);
      check("rst_cnt", stall_cnt, 0);
      check("rst_be", 32'(be), 0);
      check("rst_rdata", rdata, 0);
      @(negedge clk); rst_n = 1;
      @(posedge clk); #1;

      // Word load, ready on first BUS cycle
      access(0, 2'b10, 0, 32'h10, 32'h0, 0, 32'h8899AABB);
      check("wl_addr", r_addr, 32'h10);
      check("wl_be", 32'(r_be), 32'hF);
      check("wl_dout", r_dout, 0);
      check("wl_stall", n_stall, 2);
      check("wl_done", 32'(saw_done), 1);
      check("wl_rdata", r_rdata, 32'h8899AABB);
      check("wl_cnt", r_cnt, 2);

      // Byte loads with sign / zero extension
      access(0, 2'b00, 1, 32'h13, 32'h0, 0, 32'h80FFFFFF);
      check("bls_rdata", r_rdata, 32'hFFFFFF80);
      check("bls_be", 32'(r_be), 32'h8);
      access(0, 2'b00, 0, 32'h13, 32'h0, 0, 32'h80FFFFFF);
      check("blz_rdata", r_rdata, 32'h00000080);
      check("blz_cnt", r_cnt, 6);

      // Half load, upper lane, sign extended
      access(0, 2'b01, 1, 32'h22, 32'h0, 1, 32'h80011234);
      check("hl_rdata", r_rdata, 32'hFFFF8001);
      check("hl_stall", n_stall, 3);

      // Half store with 3 wait cycles
      access(1, 2'b01, 0, 32'h22, 32'h0000BEEF, 3, 32'h12345678);
      check("hs_dout", r_dout, 32'hBEEFBEEF);
      check("hs_be", 32'(r_be), 32'hC);
      check("hs_memw", 32'(r_memw), 1);
      check("hs_addr", r_addr, 32'h20);
      check("hs_stall", n_stall, 5);
      check("hs_done", 32'(saw_done), 1);
      check("hs_rdata", r_rdata, 0);

      // Byte store lane replication
      access(1, 2'b00, 0, 32'h41, 32'h0000005A, 0, 32'h0);
      check("bs_dout", r_dout, 32'h5A5A5A5A);
      check("bs_be", 32'(r_be), 32'h2);

      // Misaligned word load
      access(0, 2'b10, 0, 32'h06, 32'h0, 0, 32'hFFFFFFFF);
      check("mis_bus", n_bus, 0);
      check("mis_err", 32'(saw_err), 1);
      check("mis_done", 32'(saw_done), 0);
      check("mis_stall", n_stall, 1);
      check("mis_rdata", r_rdata, 0);

      // Timeout: ready never comes
      access(0, 2'b10, 0, 32'h30, 32'h0, -1, 32'h0);
      check("to_bus", n_bus, 4);
      check("to_err", 32'(saw_err), 1);
      check("to_done", 32'(saw_done), 0);

      // Ready on 4th BUS cycle beats timeout
      access(0, 2'b10, 0, 32'h30, 32'h0, 3, 32'hCAFEF00D);
      check("tr_bus", n_bus, 4);
      check("tr_done", 32'(saw_done), 1);
      check("tr_err", 32'(saw_err), 0);
      check("tr_rdata", r_rdata, 32'hCAFEF00D);

      // Asynchronous reset during BUS
      req = 1; we = 0; size = 2'b10; addr = 32'h50; MIO_ready = 0;
      @(posedge clk); #1;
      check("ar_bus", 32'(CPU_MIO), 1);
      #2 rst_n = 0; #1;
      check("ar_cpu_mio", 32'(CPU_MIO), 0);
      check("ar_stall", 32'(stall), 0);
      check("ar_cnt", stall_cnt, 0);
      req = 0;
      @(negedge clk); rst_n = 1;
      @(posedge clk); #1;
      access(0, 2'b10, 0, 32'h54, 32'h0, 0, 32'h01020304);
      check("ar2_done", 32'(saw_done), 1);
      check("ar2_rdata", r_rdata, 32'h01020304);
      check("ar2_cnt", r_cnt, 2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mips_mio_bridge.md
Name: mips_mio_bridge

Overview:
- Sequential memory-access unit between the MIPS core datapath and the MIO bus.
- Replaces direct combinational drive of Addr_out/Data_out/mem_w with a handshaked, stalling bus master.
- Adds byte/halfword/word access with byte enables, load sign/zero extension, misalignment detection, a bus timeout, and a stall-cycle counter.

Parameters:
- ADDR_W, 32: width of core and bus address.
- TIMEOUT, 255: bus cycles without MIO_ready before error; 0 disables the timeout.
- CNT_W, 32: width of the stall-cycle counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  1  core memory request; held stable while stall=1.
- we  in  1  1=store, 0=load.
- size  in  2  00=byte, 01=half, 10=word, 11=reserved (treated as word).
- sign_ext  in  1  load extension: 1=sign, 0=zero.
- addr  in  ADDR_W  byte address.
- wdata  in  32  store data, right-aligned.
- stall  out  1  freeze core.
- rdata  out  32  extended load data; valid while done=1.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle error pulse (misaligned or timeout).
- stall_cnt  out  CNT_W  total stalled cycles; saturating.
- MIO_ready  in  1  bus transfer complete.
- Data_in  in  32  bus read data.
- CPU_MIO  out  1  bus request.
- mem_w  out  1  bus write.
- Addr_out  out  ADDR_W  word-aligned bus address (low 2 bits zero).
- Data_out  out  32  lane-replicated store data.
- be  out  4  byte enables.

Behaviour:
- States: IDLE, BUS, DONE, ERR.
- Reset (async, immediate):
  - State goes to IDLE.
  - Outputs go to zero: stall, done, err, CPU_MIO, mem_w, Addr_out, Data_out, be, rdata, stall_cnt.
  - Reset during BUS drops CPU_MIO in the same instant; no completion is reported.

IDLE:
- stall = req (combinational).
- On req:
  - Misalignment check: half with addr[0]=1, or word/reserved with addr[1:0]!=0.
  - Misaligned: next state ERR, no bus cycle.
  - Aligned: latch we, size, sign_ext, addr, wdata; clear timeout counter; next state BUS.

BUS:
- stall=1, CPU_MIO=1, mem_w=we_q, Addr_out={addr_q[ADDR_W-1:2],2'b00}.
- Store lanes:
  - Byte: Data_out={4{wdata_q[7:0]}}, be=4'b0001<<addr_q[1:0].
  - Half: Data_out={2{wdata_q[15:0]}}, be=addr_q[1]?4'b1100:4'b0011.
  - Word: Data_out=wdata_q, be=4'b1111.
- Loads drive the same be; Data_out=0.
- MIO_ready=1:
  - Loads capture Data_in into rdata.
  - Lane select: byte at addr_q[1:0]*8, half at addr_q[1]*16.
  - Extend to 32 bits per sign_ext_q.
  - Next state DONE.
- Else counter+1.
  - If TIMEOUT!=0 and counter==TIMEOUT-1, next state ERR.
  - MIO_ready in that same cycle wins over timeout.
- MIO_ready is ignored outside BUS.

DONE:
- stall=0, done=1, CPU_MIO=0.
- rdata holds the extended value; stores return rdata=0.
- The core advances at this edge; req is ignored here.
- Next state IDLE.

ERR:
- stall=0, err=1, done=0, rdata=0, CPU_MIO=0.
- Next state IDLE.

Latency and counter:
- Minimum access is 3 cycles (IDLE accept, BUS, DONE); stall is high for 2 of them.
- Each wait cycle adds 1.
- stall_cnt increments on every cycle stall=1 and saturates at all-ones.
- Back-to-back: a new req is accepted in the IDLE cycle following DONE/ERR.

Test Plan:
- Word load, addr=0x10, MIO_ready high first BUS cycle, Data_in=0x8899AABB:
  - Addr_out=0x10, be=1111, stall 2 cycles.
  - done pulse with rdata=0x8899AABB; stall_cnt=2.
- Byte load sign_ext=1, addr=0x13, Data_in=0x80FFFFFF:
  - rdata=0xFFFFFF80.
  - Same with sign_ext=0: rdata=0x00000080.
- Half store addr=0x22, wdata=0x0000BEEF, ready after 3 wait cycles:
  - Data_out=0xBEEFBEEF, be=1100, mem_w=1 during BUS, stall 5 cycles, done pulse.
- Word load addr=0x06:
  - No CPU_MIO assertion; err pulse on the cycle after req; stall high 1 cycle; rdata=0.
- TIMEOUT=4, MIO_ready never asserts:
  - CPU_MIO high exactly 4 cycles, then err pulse.
  - Repeat with MIO_ready on the 4th BUS cycle: done, no err.
- rst_n low mid-BUS:
  - CPU_MIO, stall, stall_cnt drop to 0 without waiting for clk.
  - After release, a fresh word load completes normally.
